// File: rtl/dmem_mmio_responder.sv
// Data-port responder: routes CPU loads/stores between d_mem and a small MMIO test-device
// register file that implements the end-of-test protocol (TOHOST, CHKSUM, CYCLE, STATUS).
module dmem_mmio_responder #(
   parameter int unsigned                  DATA_W      = 32,
   parameter int unsigned                  ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0]        MMIO_BASE   = ADDR_WIDTH'(8'hF0),
   parameter int unsigned                  TIMEOUT_CYC = 5000
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cpu_wr_en,
   input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
   input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
   input  logic [1:0]            cpu_mode,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  mem_wr_en,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [DATA_W-1:0]     fail_code,
   output logic                  err
);

   localparam logic [DATA_W-1:0] CYC_LAST = DATA_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]        MODE_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] chksum;
   logic [DATA_W-1:0] cycle;
   logic [DATA_W-1:0] status_word;
   logic              mmio_wr;
   logic              mmio_rd;
   logic              st_legal;
   logic              st_illegal;
   logic              tohost_st;
   logic              chksum_st;
   logic              run;
   logic              fail_st;

   // Address decode and store qualification
   always_comb begin
      mmio_wr    = (cpu_wr_addr >= MMIO_BASE);
      mmio_rd    = (cpu_rd_addr >= MMIO_BASE);
      mem_wr_en  = cpu_wr_en & ~mmio_wr;
      st_legal   = cpu_wr_en & mmio_wr & (cpu_mode == MODE_WORD) & (cpu_wr_addr[1:0] == 2'b00);
      st_illegal = cpu_wr_en & mmio_wr & ~st_legal;
      tohost_st  = st_legal & (cpu_wr_addr[3:2] == 2'd0);
      chksum_st  = st_legal & (cpu_wr_addr[3:2] == 2'd1);
   end

   // A TOHOST store on the threshold cycle takes priority over TIMEOUT
   always_comb begin
      state_nxt = state;
      if (state == S_RUN) begin
         if (tohost_st) begin
            state_nxt = (cpu_wdata == DATA_W'(1)) ? S_PASS : S_FAIL;
         end else if (cycle == CYC_LAST) begin
            state_nxt = S_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= S_RUN;
         chksum    <= '0;
         cycle     <= '0;
         fail_code <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_RUN) begin
            if (chksum_st) begin
               chksum <= chksum + cpu_wdata;
            end
            if (st_illegal) begin
               err <= 1'b1;
            end
            if (tohost_st && (cpu_wdata != DATA_W'(1))) begin
               fail_code <= cpu_wdata;
            end
            // CYCLE counts only cycles that complete in RUN, so it freezes on the exit edge
            if (state_nxt == S_RUN) begin
               cycle <= cycle + DATA_W'(1);
            end
         end
      end
   end

   always_comb begin
      run     = (state == S_RUN);
      done    = ~run;
      pass    = (state == S_PASS);
      fail_st = (state == S_FAIL);
      timeout = (state == S_TIMEOUT);
      status_word = {{(DATA_W-6){1'b0}}, err, timeout, fail_st, pass, done, run};
   end

   always_comb begin
      cpu_rdata = mem_rdata;
      if (mmio_rd) begin
         case (cpu_rd_addr[3:2])
            2'd0:    cpu_rdata = '0;
            2'd1:    cpu_rdata = chksum;
            2'd2:    cpu_rdata = cycle;
            default: cpu_rdata = status_word;
         endcase
      end
   end

endmodule
